rgb_sequencer: RTL and testbench
================================

RGB_SEQUENCER -- requirements
Module: rgb_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of RGB LED channels (1..8).
REQ-002 SHALL have parameter STEP_CYCLES, default 10_000_000, clk cycles per colour step (>=1; 0.1 s at 100 MHz).
REQ-003 SHALL have parameter PWM_W, default 8, brightness/PWM counter width (>=1).
REQ-004 SHALL have parameter PHASE, default 0, colour-index offset added per channel (0..7).
REQ-005 SHALL have parameter INVERT_ODD, default 1; when 1, odd-numbered channels output the bitwise complement of their colour.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port en  input  1  show enable; 0 = all LEDs dark.
REQ-009 SHALL have port mode  input  2  0=CYCLE, 1=REVERSE, 2=BLINK, 3=HOLD.
REQ-010 SHALL have port brightness  input  PWM_W  PWM duty level, 0 = dark.
REQ-011 SHALL have port rgb  output  3*N_CH  channel k on bits [3k+2:3k], order {R,G,B}, registered.
REQ-012 SHALL have port step_pulse  output  1  one-cycle strobe on each colour step.
REQ-013 SHALL have port color_idx  output  3  current base colour index, registered.

Function
REQ-014 Colour table SHALL be: 0 red 100, 1 orange 110, 2 green 010, 3 teal 011, 4 blue 001, 5 violet 101, 6 white 111, 7 off 000.
REQ-015 Step counter SHALL count 0..STEP_CYCLES-1 while en=1, wrap to 0, and assert step_pulse for exactly the wrap cycle; held at 0 while en=0.
REQ-016 On step_pulse, idx SHALL update per mode sampled that cycle: CYCLE idx+1 mod 8; REVERSE idx-1 mod 8; BLINK 6->7, any other ->6; HOLD unchanged.
REQ-017 Mode changes SHALL take effect only at the next step_pulse; step counter SHALL NOT restart on mode change.
REQ-018 Channel k base colour SHALL be table[(idx + k*PHASE) mod 8], complemented if INVERT_ODD=1 and k odd.
REQ-019 Free-running PWM_W-bit counter pwm_cnt SHALL increment every cycle with wrap-around.
REQ-020 Brightness SHALL be latched into bri_q only when pwm_cnt = 0 (glitch-free duty change).
REQ-021 Each colour bit SHALL drive its rgb bit high iff en=1, colour bit=1 and pwm_cnt < bri_q; max duty is (2^PWM_W-1)/2^PWM_W.
REQ-022 rgb SHALL reflect idx/pwm_cnt/bri_q with exactly one cycle of register latency.
REQ-023 en 1->0 SHALL force idx=0, step counter=0 and rgb=0 on the next edge; re-enable SHALL start at red (idx 0).
REQ-024 STEP_CYCLES=1 SHALL produce step_pulse on every enabled cycle.
REQ-025 step_pulse coincident with en falling SHALL be discarded (en=0 priority).

Reset
REQ-026 rst=1 SHALL on the next edge set idx=0, step counter=0, pwm_cnt=0, bri_q=0, rgb=0, step_pulse=0, color_idx=0.
REQ-027 rst SHALL have priority over en, mode and step_pulse, including mid-step.

Structure
REQ-028 Package rgb_show_pkg SHALL hold the colour constants, the 8-entry colour table function and the mode encodings.
REQ-029 Step counter/strobe SHALL be a sub-module step_tick_gen (params CYCLES; ports clk, rst, en, tick).
REQ-030 Per-channel colour/PWM logic SHALL be a generate loop over N_CH inside rgb_sequencer.

Verification (N_CH=2, STEP_CYCLES=4, PWM_W=2, PHASE=0, INVERT_ODD=1)
REQ-031 rst, then en=1, mode=0, brightness=3 -> step_pulse every 4 cycles; color_idx 0,1,..,7,0; ch0 while idx=0 on 3 of 4 cycles as 100, ch1 as 011.
REQ-032 mode=1 from idx=2 -> sequence 1,0,7,6; mode=3 -> idx frozen, step_pulse continues.
REQ-033 mode=2 from idx=3 -> idx 6,7,6,7 at successive step_pulses; mode change mid-step does not shift pulse timing.
REQ-034 brightness=0 -> rgb=0; brightness 1->2 mid-PWM-period -> duty changes only after pwm_cnt=0 (1/4 then 2/4).
REQ-035 en dropped at idx=5 -> rgb=0 next cycle; en re-raised -> color_idx=0, first step_pulse 4 cycles later.
REQ-036 rst asserted during mode=0, idx=4 -> all outputs 0 next cycle; after release with en=1, restarts at red.

Source files
------------

// File: rtl/rgb_show_pkg.sv
// Shared constants for the RGB light show: colour codes, mode encodings and
// the 8-entry colour lookup used by every channel.
package rgb_show_pkg;

    typedef enum logic [1:0] {
        ModeCycle   = 2'd0,
        ModeReverse = 2'd1,
        ModeBlink   = 2'd2,
        ModeHold    = 2'd3
    } mode_e;

    // Colour codes are {R,G,B}.
    localparam logic [2:0] ColRed    = 3'b100;
    localparam logic [2:0] ColOrange = 3'b110;
    localparam logic [2:0] ColGreen  = 3'b010;
    localparam logic [2:0] ColTeal   = 3'b011;
    localparam logic [2:0] ColBlue   = 3'b001;
    localparam logic [2:0] ColViolet = 3'b101;
    localparam logic [2:0] ColWhite  = 3'b111;
    localparam logic [2:0] ColOff    = 3'b000;

    localparam logic [2:0] IdxWhite = 3'd6;
    localparam logic [2:0] IdxOff   = 3'd7;

    function automatic logic [2:0] color_lut(input logic [2:0] idx);
        logic [2:0] col;
        unique case (idx)
            3'd0:    col = ColRed;
            3'd1:    col = ColOrange;
            3'd2:    col = ColGreen;
            3'd3:    col = ColTeal;
            3'd4:    col = ColBlue;
            3'd5:    col = ColViolet;
            3'd6:    col = ColWhite;
            default: col = ColOff;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step timer: counts enabled cycles and strobes tick on the wrap cycle.
// The strobe is gated by en so a step coinciding with en falling is dropped.
module step_tick_gen #(
    parameter int unsigned CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CntW'(CYCLES - 1));
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_sequencer.sv
// Multi-channel RGB colour sequencer with PWM brightness; each channel shows
// the shared colour index offset by k*PHASE, odd channels optionally inverted.
module rgb_sequencer
    import rgb_show_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned STEP_CYCLES = 10_000_000,
    parameter int unsigned PWM_W       = 8,
    parameter int unsigned PHASE       = 0,
    parameter bit          INVERT_ODD  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [PWM_W-1:0]  brightness,
    output logic [3*N_CH-1:0] rgb,
    output logic              step_pulse,
    output logic [2:0]        color_idx
);

    logic              tick;
    logic [2:0]        idx_q, idx_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0]  bri_q, bri_d;
    logic [3*N_CH-1:0] rgb_q, rgb_d;
    logic              pwm_on;

    step_tick_gen #(
        .CYCLES(STEP_CYCLES)
    ) u_step_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    always_comb begin
        idx_d = idx_q;
        if (!en) begin
            idx_d = 3'd0;
        end else if (tick) begin
            unique case (mode_e'(mode))
                ModeCycle:   idx_d = idx_q + 3'd1;
                ModeReverse: idx_d = idx_q - 3'd1;
                ModeBlink:   idx_d = (idx_q == IdxWhite) ? IdxOff : IdxWhite;
                ModeHold:    idx_d = idx_q;
                default:     idx_d = idx_q;
            endcase
        end
    end

    // Brightness only changes at the PWM period boundary to avoid duty glitches.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        bri_d     = (pwm_cnt_q == '0) ? brightness : bri_q;
        pwm_on    = pwm_cnt_q < bri_q;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam bit Inv = INVERT_ODD && (k % 2 == 1);
        logic [2:0] base_idx;
        logic [2:0] col;

        assign base_idx = idx_q + 3'(k * PHASE);
        assign col      = color_lut(base_idx) ^ {3{Inv}};
        assign rgb_d[3*k +: 3] = (en && pwm_on) ? col : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= 3'd0;
            pwm_cnt_q <= '0;
            bri_q     <= '0;
            rgb_q     <= '0;
        end else begin
            idx_q     <= idx_d;
            pwm_cnt_q <= pwm_cnt_d;
            bri_q     <= bri_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign step_pulse = tick;
    assign color_idx  = idx_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed bench for rgb_sequencer with N_CH=2, STEP_CYCLES=4, PWM_W=2, PHASE=0,
// INVERT_ODD=1: vector tables for cycle-exact behaviour plus step-level sequences.
module tb_rgb_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] brightness;
    logic [5:0] rgb;
    logic       step_pulse;
    logic [2:0] color_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [1:0] bri;
        logic [5:0] rgb;
        logic       sp;
        logic [2:0] ci;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    rgb_sequencer #(
        .N_CH       (2),
        .STEP_CYCLES(4),
        .PWM_W      (2),
        .PHASE      (0),
        .INVERT_ODD (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .brightness(brightness),
        .rgb       (rgb),
        .step_pulse(step_pulse),
        .color_idx (color_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [1:0] b, input logic [5:0] c,
                                input logic s, input logic [2:0] i);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.bri = b; v.rgb = c; v.sp = s; v.ci = i;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag, input vec_t tab[$]);
        for (int i = 0; i < tab.size(); i++) begin
            rst        = tab[i].rst;
            en         = tab[i].en;
            mode       = tab[i].mode;
            brightness = tab[i].bri;
            step_clk();
            check($sformatf("%s%0d rgb", tag, i), 32'(rgb), 32'(tab[i].rgb));
            check($sformatf("%s%0d step_pulse", tag, i), 32'(step_pulse), 32'(tab[i].sp));
            check($sformatf("%s%0d color_idx", tag, i), 32'(color_idx), 32'(tab[i].ci));
        end
    endtask

    // Clock until step_pulse is seen (bounded), check the spacing, then take the
    // step edge and check the new colour index.
    task automatic advance(input string name, input int exp_n, input logic [2:0] exp_idx);
        int n;
        n = 0;
        do begin
            step_clk();
            n++;
        end while (!step_pulse && n < 12);
        check({name, " pulse spacing"}, 32'(n), 32'(exp_n));
        step_clk();
        check({name, " color_idx"}, 32'(color_idx), 32'(exp_idx));
    endtask

    initial begin
        logic [2:0] seq_cyc [8];
        logic [2:0] seq_rev [4];
        logic [2:0] seq_blk [4];

        // rst, en, mode, bri, rgb{ch1,ch0}, step_pulse, color_idx
        tab_a.push_back(mk(1, 0, 0, 3, 6'b000000, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b000000, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b011100, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b011100, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b000000, 0, 1));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b001110, 0, 1));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b001110, 0, 1));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b001110, 1, 1));
        tab_a.push_back(mk(0, 1, 0, 3, 6'b000000, 0, 2));

        // Brightness 0, then 1 -> 2 mid-period, en drop at idx 5, en drop on a step.
        tab_b.push_back(mk(1, 1, 0, 0, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 1, 0, 0, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 1, 0, 0, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 1, 0, 0, 6'b000000, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 0, 6'b000000, 0, 1));
        tab_b.push_back(mk(0, 1, 0, 1, 6'b000000, 0, 1));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 1));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 1, 1));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 2));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b101010, 0, 2));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b101010, 0, 2));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 1, 2));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 3));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b100011, 0, 3));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b100011, 0, 3));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 1, 3));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 4));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b110001, 0, 4));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b110001, 0, 4));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 1, 4));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 5));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b010101, 0, 5));
        tab_b.push_back(mk(0, 0, 0, 2, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b011100, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b011100, 0, 1));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 1));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b000000, 0, 1));
        tab_b.push_back(mk(0, 1, 0, 2, 6'b001110, 1, 1));
        tab_b.push_back(mk(0, 0, 0, 2, 6'b000000, 0, 0));
        tab_b.push_back(mk(0, 0, 0, 2, 6'b000000, 0, 0));

        seq_cyc = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        seq_rev = '{3'd1, 3'd0, 3'd7, 3'd6};
        seq_blk = '{3'd6, 3'd7, 3'd6, 3'd7};

        rst = 1'b1; en = 1'b0; mode = 2'd0; brightness = 2'd3;

        run_table("a", tab_a);

        // State here: idx 2 at the start of a step, mode CYCLE.
        for (int i = 0; i < 8; i++) advance($sformatf("cycle%0d", i), 3, seq_cyc[i]);
        mode = 2'd1;
        for (int i = 0; i < 4; i++) advance($sformatf("reverse%0d", i), 3, seq_rev[i]);
        mode = 2'd3;
        for (int i = 0; i < 2; i++) advance($sformatf("hold%0d", i), 3, 3'd6);
        mode = 2'd1;
        for (int i = 0; i < 3; i++) advance($sformatf("rev_to3_%0d", i), 3, 3'd5 - 3'(i));
        mode = 2'd2;
        for (int i = 0; i < 4; i++) advance($sformatf("blink%0d", i), 3, seq_blk[i]);

        // Mode change one cycle into a step: pulse timing unchanged, new mode applies.
        step_clk();
        mode = 2'd0;
        advance("midstep", 2, 3'd0);

        run_table("b", tab_b);

        // Reset mid-step at idx 4 in CYCLE mode.
        en = 1'b1; mode = 2'd0;
        for (int i = 0; i < 4; i++) advance($sformatf("to4_%0d", i), 3, 3'(i + 1));
        step_clk();
        step_clk();
        rst = 1'b1;
        step_clk();
        check("rst rgb", 32'(rgb), 32'(0));
        check("rst step_pulse", 32'(step_pulse), 32'(0));
        check("rst color_idx", 32'(color_idx), 32'(0));
        rst = 1'b0;
        step_clk();
        check("post_rst1 rgb", 32'(rgb), 32'(0));
        check("post_rst1 color_idx", 32'(color_idx), 32'(0));
        step_clk();
        check("post_rst2 rgb red", 32'(rgb), 32'(6'b011100));
        check("post_rst2 color_idx", 32'(color_idx), 32'(0));
        advance("post_rst step", 1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
